// File: rtl/ins_dispatch_if.sv
// ins_dispatch_if: command strobe, status and datapath memory-port bundle
// shared between the program controller side (master) and the dispatcher
// inside the compute core (slave).
interface ins_dispatch_if #(
  parameter int ADDR_W = 10
);
  logic [41:0]       command_in;
  logic              command_we;
  logic              done_ins_computation;
  logic              busy;
  logic              cmd_err;
  logic [4:0]        op;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  modport master (
    output command_in,
    output command_we,
    input  done_ins_computation,
    input  busy,
    input  cmd_err,
    input  op,
    input  rd_en,
    input  rd_addr,
    input  wr_en,
    input  wr_addr
  );

  modport slave (
    input  command_in,
    input  command_we,
    output done_ins_computation,
    output busy,
    output cmd_err,
    output op,
    output rd_en,
    output rd_addr,
    output wr_en,
    output wr_addr
  );
endinterface

// File: rtl/ins_dispatch.sv
// ins_dispatch: accepts one 42-bit command per strobe, issues L+1 pipelined
// reads (src + i*stride) and, PIPE_LAT cycles later, the matching writes
// (dst + i), then holds done_ins_computation high until the next command.
// Optional feature macro: INS_DISPATCH_STRIDE_EN enables a power-of-two read
// stride taken from command bits [37:35]; without it the read stride is 1.
// rst is asynchronous and active-low.
module ins_dispatch #(
  parameter int ADDR_W   = 10,
  parameter int PIPE_LAT = 4
) (
  input logic          clk,
  input logic          rst,
  ins_dispatch_if.slave bus
);

  localparam int FIELD_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [4:0]         cmd_op;
  logic [FIELD_W-1:0] cmd_len;
  logic [ADDR_W-1:0]  cmd_src;
  logic [ADDR_W-1:0]  cmd_dst;
  logic               cmd_exec;
  logic               accept;
  logic               reject;

  logic [4:0]         op_q;
  logic [FIELD_W-1:0] len_q;
  logic [ADDR_W-1:0]  dst_q;
  logic [FIELD_W-1:0] rd_idx;
  logic [FIELD_W-1:0] wr_idx;
  logic               rd_en_q;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic               wr_en_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic               done_q;
  logic               busy_q;
  logic               cmd_err_q;
  logic [ADDR_W-1:0]  rd_step;

  // dly[k] is rd_en delayed by k+1 cycles; the top tap is the write strobe
  logic [PIPE_LAT-1:0] dly;
  logic [PIPE_LAT:0]   dly_next;

  assign cmd_op   = bus.command_in[4:0];
  assign cmd_len  = bus.command_in[14:5];
  assign cmd_src  = ADDR_W'(bus.command_in[24:15]);
  assign cmd_dst  = ADDR_W'(bus.command_in[34:25]);
  assign cmd_exec = (cmd_op != 5'd0) && (cmd_op != 5'd31);
  assign accept   = bus.command_we && ((state == IDLE) || (state == DONE));
  assign reject   = bus.command_we && ((state == ISSUE) || (state == DRAIN));
  assign dly_next = {dly, rd_en_q};
  assign wr_en_q  = dly[PIPE_LAT-1];

`ifdef INS_DISPATCH_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;
  logic              unused_cmd_bits;

  assign unused_cmd_bits = ^bus.command_in[41:38];
  assign rd_step         = stride_q;

  // Latch the read stride (2^code) when an executable command is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stride_q <= '0;
    end else if (accept && cmd_exec) begin
      stride_q <= ADDR_W'(1) << bus.command_in[37:35];
    end
  end
`else
  logic unused_cmd_bits;

  assign unused_cmd_bits = ^bus.command_in[41:35];
  assign rd_step         = ADDR_W'(1);
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: NOP/END go straight to DONE, DRAIN ends once the last write
  // has entered the write strobe and nothing is left behind it
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_next = cmd_exec ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (rd_idx == len_q) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (dly_next[PIPE_LAT-1:0] == '0) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs, read/write address generation and the delay line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= '0;
      len_q     <= '0;
      dst_q     <= '0;
      rd_idx    <= '0;
      wr_idx    <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      cmd_err_q <= 1'b0;
      dly       <= '0;
    end else begin
      if (accept) begin
        op_q <= cmd_op;
      end

      if (accept && cmd_exec) begin
        len_q     <= cmd_len;
        dst_q     <= cmd_dst;
        rd_idx    <= '0;
        rd_addr_q <= cmd_src;
      end else if ((state == ISSUE) && (state_next == ISSUE)) begin
        rd_idx    <= rd_idx + FIELD_W'(1);
        rd_addr_q <= rd_addr_q + rd_step;
      end

      if (accept && cmd_exec) begin
        wr_idx <= '0;
      end else if (dly_next[PIPE_LAT-1]) begin
        wr_addr_q <= dst_q + ADDR_W'(wr_idx);
        wr_idx    <= wr_idx + FIELD_W'(1);
      end

      if (reject) begin
        cmd_err_q <= 1'b1;
      end

      rd_en_q <= (state_next == ISSUE);
      busy_q  <= (state_next == ISSUE) || (state_next == DRAIN);
      done_q  <= (state_next == DONE);
      dly     <= dly_next[PIPE_LAT-1:0];
    end
  end

  assign bus.op                   = op_q;
  assign bus.rd_en                = rd_en_q;
  assign bus.rd_addr              = rd_addr_q;
  assign bus.wr_en                = wr_en_q;
  assign bus.wr_addr              = wr_addr_q;
  assign bus.done_ins_computation = done_q;
  assign bus.busy                 = busy_q;
  assign bus.cmd_err              = cmd_err_q;

endmodule
